cursor_blinker: RTL and testbench

Parametrised cursor blink sequencer for the paint pipeline. One `init` starts one blink cycle:
- Paint a square cursor footprint of CUR_SIZE x CUR_SIZE pixels at a latched coordinate in an "on" colour, then hold.
- Repaint the footprint in an "off" colour, then hold.
- Pulse `cursor_done`.

Hold durations are counted internally, with no external counters. Each pixel write uses a paint/ack handshake with the framebuffer writer. Footprint pixels past the screen edge are clipped.

---
 rtl/cursor_blinker_if.sv | 10 +
 rtl/cursor_blinker.sv | 94 +++++++++
 tb/tb_cursor_blinker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cursor_blinker_if.sv
// cursor_blinker_if: pixel paint/ack handshake between the blinker and the framebuffer writer
interface cursor_blinker_if #(parameter int COORD_W = 6, parameter int PX_W = 8);
  logic paint;
  logic paint_ack;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [PX_W-1:0] px_data;
  modport master(output paint, out_x, out_y, px_data, input paint_ack);
  modport slave(input paint, out_x, out_y, px_data, output paint_ack);
endinterface

// File: rtl/cursor_blinker.sv
// cursor_blinker: paints a square cursor in the on colour, holds, repaints it in the off colour, holds, pulses done
module cursor_blinker #(
  parameter int COORD_W = 6,
  parameter int PX_W = 8,
  parameter int CUR_SIZE = 2,
  parameter int ON_TICKS = 24,
  parameter int OFF_TICKS = 24,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [PX_W-1:0] color_on,
  input  logic [PX_W-1:0] color_off,
  input  logic blink_en,
  cursor_blinker_if.master pb,
  output logic busy,
  output logic cursor_done
);
  localparam logic [2:0] IDLE = 3'd0, PAINT_ON = 3'd1, HOLD_ON = 3'd2, PAINT_OFF = 3'd3, HOLD_OFF = 3'd4, DONE = 3'd5;
  localparam logic [1:0] LAST = 2'(CUR_SIZE - 1);
  logic [2:0] st, ns;
  logic [1:0] dx, dy, ndx, ndy;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [COORD_W-1:0] x0, y0, nx0, ny0;
  logic [PX_W-1:0] con, coff, ncon, ncoff;
  logic blink, nblink, start, in_paint, adv, last, step, hold;
  logic [COORD_W:0] px, py;
  // outputs are registered from next-state values so a request appears the cycle after it is decided
  always_comb begin
    start = st == IDLE && init;
    nx0 = start ? in_x : x0;
    ny0 = start ? in_y : y0;
    ncon = start ? color_on : con;
    ncoff = start ? color_off : coff;
    nblink = start ? blink_en : blink;
    in_paint = st == PAINT_ON || st == PAINT_OFF;
    hold = st == HOLD_ON || st == HOLD_OFF;
    adv = in_paint && (!pb.paint || pb.paint_ack);
    last = dx == LAST && dy == LAST;
    step = adv && !last;
    ndx = step ? (dx == LAST ? 2'd0 : dx + 2'd1) : (in_paint && !adv) ? dx : 2'd0;
    ndy = step ? (dx == LAST ? dy + 2'd1 : dy) : (in_paint && !adv) ? dy : 2'd0;
    ns = st;
    case (st)
      IDLE: ns = init ? PAINT_ON : IDLE;
      PAINT_ON: ns = (adv && last) ? (blink ? HOLD_ON : DONE) : PAINT_ON;
      HOLD_ON: ns = cnt == '0 ? PAINT_OFF : HOLD_ON;
      PAINT_OFF: ns = (adv && last) ? HOLD_OFF : PAINT_OFF;
      HOLD_OFF: ns = cnt == '0 ? DONE : HOLD_OFF;
      default: ns = IDLE;
    endcase
    ncnt = hold ? cnt - CNT_W'(1) : st == PAINT_ON ? CNT_W'(ON_TICKS - 1) : CNT_W'(OFF_TICKS - 1);
    px = {1'b0, nx0} + (COORD_W + 1)'(ndx);
    py = {1'b0, ny0} + (COORD_W + 1)'(ndy);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      dx <= '0;
      dy <= '0;
      cnt <= '0;
      x0 <= '0;
      y0 <= '0;
      con <= '0;
      coff <= '0;
      blink <= 1'b0;
      pb.paint <= 1'b0;
      pb.out_x <= '0;
      pb.out_y <= '0;
      pb.px_data <= '0;
      busy <= 1'b0;
      cursor_done <= 1'b0;
    end else begin
      st <= ns;
      dx <= ndx;
      dy <= ndy;
      cnt <= ncnt;
      x0 <= nx0;
      y0 <= ny0;
      con <= ncon;
      coff <= ncoff;
      blink <= nblink;
      pb.paint <= (ns == PAINT_ON || ns == PAINT_OFF) && !px[COORD_W] && !py[COORD_W];
      pb.out_x <= px[COORD_W-1:0];
      pb.out_y <= py[COORD_W-1:0];
      pb.px_data <= ns == PAINT_OFF ? ncoff : ncon;
      busy <= ns != IDLE;
      cursor_done <= ns == DONE;
    end
  end
endmodule

// File: tb/tb_cursor_blinker.sv
// tb_cursor_blinker: scoreboard bench, expected pixel writes and done cycles queued by stimulus, checked by a monitor
module tb_cursor_blinker;
  logic clk = 0, rst = 0, init = 0, blink_en = 0;
  logic [5:0] in_x = 0, in_y = 0;
  logic [7:0] color_on = 0, color_off = 0;
  logic busy, cursor_done;
  int errors = 0, checks = 0, cyc = 0, n0 = 0;
  typedef struct {int x; int y; int d;} pix_t;
  pix_t exp_q[$];
  pix_t mon_e;
  int done_q[$];
  cursor_blinker_if #(.COORD_W(6), .PX_W(8)) pb();
  cursor_blinker #(.COORD_W(6), .PX_W(8), .CUR_SIZE(2), .ON_TICKS(4), .OFF_TICKS(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .init(init), .in_x(in_x), .in_y(in_y), .color_on(color_on),
    .color_off(color_off), .blink_en(blink_en), .pb(pb.master), .busy(busy), .cursor_done(cursor_done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (rst) begin
    if (pb.paint && pb.paint_ack) begin
      if (exp_q.size() == 0) chk("unexpected_paint", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("pix_x", int'(pb.out_x), mon_e.x);
        chk("pix_y", int'(pb.out_y), mon_e.y);
        chk("pix_data", int'(pb.px_data), mon_e.d);
      end
    end
    if (cursor_done) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_cycle", cyc - n0 + 1, done_q.pop_front() - n0 + 1);
    end
  end
  task automatic push_phase(int x, int y, int d);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++)
        if (x + i < 64 && y + j < 64) exp_q.push_back('{x + i, y + j, d});
  endtask
  task automatic start(int x, int y, int con, int coff, int bl, int done_k);
    @(posedge clk); #1;
    in_x = 6'(x); in_y = 6'(y); color_on = 8'(con); color_off = 8'(coff); blink_en = bl[0]; init = 1;
    @(posedge clk); #1;
    n0 = cyc; init = 0;
    push_phase(x, y, con);
    if (bl != 0) push_phase(x, y, coff);
    done_q.push_back(n0 + done_k - 1);
  endtask
  task automatic at_cycle(int k);
    do @(negedge clk); while (cyc < n0 + k - 1);
  endtask
  task automatic after_edge(int k);
    do begin @(posedge clk); #1; end while (cyc < n0 + k);
  endtask
  task automatic drain(string name);
    int i = 0;
    while ((busy || exp_q.size() != 0 || done_q.size() != 0) && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_pix_left"}, exp_q.size(), 0);
    chk({name, "_done_left"}, done_q.size(), 0);
    chk({name, "_idle"}, int'(busy), 0);
  endtask
  task automatic chk_zero(string name);
    chk({name, "_paint"}, int'(pb.paint), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(cursor_done), 0);
    chk({name, "_x"}, int'(pb.out_x), 0);
    chk({name, "_y"}, int'(pb.out_y), 0);
    chk({name, "_data"}, int'(pb.px_data), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    pb.paint_ack = 1;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1;
    start(10, 20, 8'hFF, 8'h00, 1, 16);
    at_cycle(1);
    chk("t1_first_paint", int'(pb.paint), 1);
    at_cycle(5);
    chk("t1_hold_paint", int'(pb.paint), 0);
    at_cycle(16);
    chk("t1_busy16", int'(busy), 1);
    at_cycle(17);
    chk("t1_busy17", int'(busy), 0);
    drain("t1");
    start(63, 62, 8'hFF, 8'h00, 1, 16);
    at_cycle(2);
    chk("t2_clip_paint", int'(pb.paint), 0);
    chk("t2_clip_busy", int'(busy), 1);
    drain("t2");
    pb.paint_ack = 0;
    start(10, 20, 8'hFF, 8'h00, 1, 21);
    for (int k = 1; k <= 5; k++) begin
      at_cycle(k);
      chk("t3_stall_paint", int'(pb.paint), 1);
      chk("t3_stall_x", int'(pb.out_x), 10);
      chk("t3_stall_y", int'(pb.out_y), 20);
      chk("t3_stall_data", int'(pb.px_data), 255);
    end
    after_edge(5);
    pb.paint_ack = 1;
    at_cycle(7);
    chk("t3_second_x", int'(pb.out_x), 11);
    drain("t3");
    start(40, 8, 8'h5A, 8'hA5, 0, 5);
    at_cycle(6);
    chk("t4_busy6", int'(busy), 0);
    drain("t4");
    start(10, 20, 8'hFF, 8'h00, 1, 16);
    at_cycle(6);
    #1 rst = 0;
    #1 chk_zero("t5_async");
    exp_q.delete();
    done_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (30) @(negedge clk);
    chk("t5_after_busy", int'(busy), 0);
    start(5, 7, 8'hC3, 8'h3C, 1, 16);
    drain("t5");
    start(10, 20, 8'hFF, 8'h00, 1, 16);
    after_edge(9);
    init = 1;
    in_x = 6'd30;
    after_edge(11);
    init = 0;
    drain("t6a");
    start(30, 20, 8'h11, 8'h22, 1, 16);
    drain("t6b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
